lock_sequence_controller: RTL and testbench

//  Central FSM of the digital lock. Consumes the one-cycle button-press pulses from the button

---
 rtl/lock_sequence_controller_pkg.sv | 29 ++
 rtl/lock_sequence_controller_if.sv | 27 ++
 rtl/lock_sequence_controller_countdown_timer.sv | 34 +++
 rtl/lock_sequence_controller.sv | 160 ++++++++++++++++
 tb/tb_lock_sequence_controller.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lock_sequence_controller_pkg.sv
// Shared types and constants for the digital lock sequencing logic.
package lock_sequence_controller_pkg;

   localparam int unsigned DigitW     = 2;
   localparam int unsigned NumButtons = 4;

   localparam int unsigned DefCodeLen       = 4;
   localparam int unsigned DefMaxFails      = 3;
   localparam int unsigned DefLockoutCycles = 50_000_000;
   localparam int unsigned DefEntryTimeout  = 250_000_000;

   typedef enum logic [1:0] {
      StLocked   = 2'd0,
      StUnlocked = 2'd1,
      StSetCode  = 2'd2,
      StLockout  = 2'd3
   } state_e;

   // Several buttons in one cycle: the lowest set index is the digit.
   function automatic logic [DigitW-1:0] decode_press(input logic [NumButtons-1:0] presses);
      logic [DigitW-1:0] digit;
      digit = '0;
      for (int i = NumButtons - 1; i >= 0; i--) begin
         if (presses[i]) digit = DigitW'(i);
      end
      return digit;
   endfunction

endpackage

// File: rtl/lock_sequence_controller_if.sv
// Button/status bundle between the button monitor, the lock controller and the display drivers.
interface lock_sequence_controller_if #(
   parameter int unsigned CodeLen = 4
) ();
   import lock_sequence_controller_pkg::*;

   localparam int unsigned CountW = $clog2(CodeLen + 1);

   logic [NumButtons-1:0] button_presses;
   logic                  set_mode;
   logic                  unlocked;
   logic                  lockout;
   logic [CountW-1:0]     digit_count;
   logic                  error_pulse;
   logic                  code_updated;

   modport master (
      output button_presses, set_mode,
      input  unlocked, lockout, digit_count, error_pulse, code_updated
   );

   modport slave (
      input  button_presses, set_mode,
      output unlocked, lockout, digit_count, error_pulse, code_updated
   );

endinterface

// File: rtl/lock_sequence_controller_countdown_timer.sv
// Loadable down-counter; expired_o flags the final cycle of a Limit-clock interval.
module lock_sequence_controller_countdown_timer #(
   parameter int unsigned Limit = 10
) (
   input  logic clock,
   input  logic reset,
   input  logic load_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int unsigned CntW = (Limit > 1) ? $clog2(Limit) : 1;

   logic [CntW-1:0] count_q, count_d;

   // Load restarts a full interval; counting stops at zero instead of wrapping.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = CntW'(Limit - 1);
      end else if (enable_i && (count_q != '0)) begin
         count_d = count_q - CntW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign expired_o = enable_i && (count_q == '0);

endmodule

// File: rtl/lock_sequence_controller.sv
// Lock FSM: assembles button digits into an entry, checks or stores passcodes, handles lockout.
module lock_sequence_controller
   import lock_sequence_controller_pkg::*;
#(
   parameter int unsigned CodeLen                      = DefCodeLen,
   parameter logic [DigitW*CodeLen-1:0] DefaultCode   = 8'b00011011,
   parameter int unsigned MaxFails                     = DefMaxFails,
   parameter int unsigned LockoutCycles                = DefLockoutCycles,
   parameter int unsigned EntryTimeout                 = DefEntryTimeout
) (
   input logic                        clock,
   input logic                        reset,
   lock_sequence_controller_if.slave  bus_io
);

   localparam int unsigned CodeW  = DigitW * CodeLen;
   localparam int unsigned CountW = $clog2(CodeLen + 1);
   localparam int unsigned FailW  = $clog2(MaxFails + 1);

   state_e             state_q, state_d;
   logic [CodeW-1:0]   entry_q, entry_d;
   logic [CodeW-1:0]   code_q, code_d;
   logic [CountW-1:0]  digit_count_q, digit_count_d;
   logic [FailW-1:0]   fail_q, fail_d;
   logic               unlocked_q, unlocked_d;
   logic               lockout_q, lockout_d;
   logic               error_q, error_d;
   logic               updated_q, updated_d;

   logic               press_valid;
   logic [DigitW-1:0]  digit;
   logic [CodeW-1:0]   shifted;
   logic               last_digit;
   logic [FailW-1:0]   fail_inc;
   logic               entry_en, entry_load, entry_expired;
   logic               lock_en, lock_load, lock_expired;

   assign press_valid = |bus_io.button_presses;
   assign digit       = decode_press(bus_io.button_presses);
   // New digit enters at the top so that after CodeLen presses digit 0 sits in the LSBs.
   assign shifted     = (entry_q >> DigitW) | (CodeW'(digit) << (CodeW - DigitW));
   assign last_digit  = (digit_count_q == CountW'(CodeLen - 1));
   assign fail_inc    = (fail_q == FailW'(MaxFails)) ? fail_q : fail_q + FailW'(1);

   assign entry_en = ((state_q == StLocked) || (state_q == StSetCode)) && (digit_count_q != '0);
   assign lock_en  = (state_q == StLockout);

   lock_sequence_controller_countdown_timer #(
      .Limit (EntryTimeout)
   ) u_entry_timer (
      .clock     (clock),
      .reset     (reset),
      .load_i    (entry_load),
      .enable_i  (entry_en),
      .expired_o (entry_expired)
   );

   lock_sequence_controller_countdown_timer #(
      .Limit (LockoutCycles)
   ) u_lockout_timer (
      .clock     (clock),
      .reset     (reset),
      .load_i    (lock_load),
      .enable_i  (lock_en),
      .expired_o (lock_expired)
   );

   // Next-state, entry/code/fail bookkeeping and one-cycle pulses.
   always_comb begin
      state_d       = state_q;
      entry_d       = entry_q;
      code_d        = code_q;
      digit_count_d = digit_count_q;
      fail_d        = fail_q;
      error_d       = 1'b0;
      updated_d     = 1'b0;
      entry_load    = 1'b0;
      lock_load     = 1'b0;

      unique case (state_q)
         StLocked, StSetCode: begin
            // A press on the timeout-expiry cycle takes priority over the timeout.
            if (press_valid) begin
               entry_load = 1'b1;
               if (last_digit) begin
                  entry_d       = '0;
                  digit_count_d = '0;
                  if (state_q == StSetCode) begin
                     code_d    = shifted;
                     updated_d = 1'b1;
                     state_d   = StUnlocked;
                  end else if (shifted == code_q) begin
                     state_d = StUnlocked;
                     fail_d  = '0;
                  end else begin
                     error_d = 1'b1;
                     fail_d  = fail_inc;
                     if (fail_inc == FailW'(MaxFails)) begin
                        state_d   = StLockout;
                        lock_load = 1'b1;
                     end
                  end
               end else begin
                  entry_d       = shifted;
                  digit_count_d = digit_count_q + CountW'(1);
               end
            end else if (entry_expired) begin
               entry_d       = '0;
               digit_count_d = '0;
               if (state_q == StSetCode) state_d = StUnlocked;
            end
         end
         StUnlocked: begin
            if (press_valid) state_d = bus_io.set_mode ? StSetCode : StLocked;
         end
         StLockout: begin
            if (lock_expired) begin
               state_d = StLocked;
               fail_d  = '0;
            end
         end
         default: state_d = StLocked;
      endcase

      unlocked_d = (state_d == StUnlocked) || (state_d == StSetCode);
      lockout_d  = (state_d == StLockout);
   end

   // State and output registers; reset restores the default passcode.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= StLocked;
         entry_q       <= '0;
         code_q        <= DefaultCode;
         digit_count_q <= '0;
         fail_q        <= '0;
         unlocked_q    <= 1'b0;
         lockout_q     <= 1'b0;
         error_q       <= 1'b0;
         updated_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         entry_q       <= entry_d;
         code_q        <= code_d;
         digit_count_q <= digit_count_d;
         fail_q        <= fail_d;
         unlocked_q    <= unlocked_d;
         lockout_q     <= lockout_d;
         error_q       <= error_d;
         updated_q     <= updated_d;
      end
   end

   assign bus_io.unlocked     = unlocked_q;
   assign bus_io.lockout      = lockout_q;
   assign bus_io.digit_count  = digit_count_q;
   assign bus_io.error_pulse  = error_q;
   assign bus_io.code_updated = updated_q;

endmodule

// File: tb/tb_lock_sequence_controller.sv
// Bench for the lock controller: directed scenarios plus random presses against a digit-list model.
module tb_lock_sequence_controller;

   localparam int CL   = 4;
   localparam int MAXF = 3;
   localparam int LOCK = 20;
   localparam int TMO  = 10;
   localparam logic [7:0] DEF = 8'b00011011;

   localparam int MLocked   = 0;
   localparam int MUnlocked = 1;
   localparam int MSetCode  = 2;
   localparam int MLockout  = 3;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   lock_sequence_controller_if #(.CodeLen(CL)) bus ();

   lock_sequence_controller #(
      .CodeLen       (CL),
      .DefaultCode   (DEF),
      .MaxFails      (MAXF),
      .LockoutCycles (LOCK),
      .EntryTimeout  (TMO)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .bus_io (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: current mode, stored digits, captured digits, idle/lockout clock counts.
   int m_state;
   int m_code[CL];
   int m_entry[$];
   int m_fails;
   int m_idle;
   int m_lock_cnt;
   bit m_err;
   bit m_upd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".unlocked"}, 32'(bus.unlocked),
            32'((m_state == MUnlocked) || (m_state == MSetCode)));
      check({tag, ".lockout"}, 32'(bus.lockout), 32'(m_state == MLockout));
      check({tag, ".digit_count"}, 32'(bus.digit_count), 32'(m_entry.size()));
      check({tag, ".error_pulse"}, 32'(bus.error_pulse), 32'(m_err));
      check({tag, ".code_updated"}, 32'(bus.code_updated), 32'(m_upd));
   endtask

   task automatic model_reset();
      logic [7:0] c;
      c = DEF;
      m_state = MLocked;
      for (int i = 0; i < CL; i++) m_code[i] = int'((c >> (2 * i)) & 8'd3);
      m_entry.delete();
      m_fails    = 0;
      m_idle     = 0;
      m_lock_cnt = 0;
      m_err      = 1'b0;
      m_upd      = 1'b0;
   endtask

   function automatic int lowest(input logic [3:0] p);
      int d;
      d = -1;
      for (int i = 0; i < 4; i++) if (p[i] && d < 0) d = i;
      return d;
   endfunction

   task automatic model_step(input logic [3:0] p, input logic s);
      bit ok;
      m_err = 1'b0;
      m_upd = 1'b0;
      if (m_state == MLocked || m_state == MSetCode) begin
         if (p != 4'd0) begin
            m_entry.push_back(lowest(p));
            m_idle = 0;
            if (m_entry.size() == CL) begin
               if (m_state == MLocked) begin
                  ok = 1'b1;
                  for (int i = 0; i < CL; i++) if (m_entry[i] != m_code[i]) ok = 1'b0;
                  if (ok) begin
                     m_state = MUnlocked;
                     m_fails = 0;
                  end else begin
                     m_err = 1'b1;
                     if (m_fails < MAXF) m_fails++;
                     if (m_fails == MAXF) begin
                        m_state    = MLockout;
                        m_lock_cnt = 0;
                     end
                  end
               end else begin
                  for (int i = 0; i < CL; i++) m_code[i] = m_entry[i];
                  m_upd   = 1'b1;
                  m_state = MUnlocked;
               end
               m_entry.delete();
            end
         end else if (m_entry.size() > 0) begin
            m_idle++;
            if (m_idle == TMO) begin
               m_entry.delete();
               if (m_state == MSetCode) m_state = MUnlocked;
            end
         end
      end else if (m_state == MUnlocked) begin
         if (p != 4'd0) m_state = s ? MSetCode : MLocked;
      end else begin
         m_lock_cnt++;
         if (m_lock_cnt == LOCK) begin
            m_state = MLocked;
            m_fails = 0;
         end
      end
   endtask

   task automatic step(input logic [3:0] p, input logic s);
      @(negedge clock);
      bus.button_presses = p;
      bus.set_mode       = s;
      @(posedge clock);
      model_step(p, s);
      #1;
      check_all("step");
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset              = 1'b1;
      bus.button_presses = 4'd0;
      bus.set_mode       = 1'b0;
      #1;
      model_reset();
      check_all("reset_async");
      @(posedge clock);
      #1;
      check_all("reset_hold");
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      model_step(4'd0, 1'b0);
      #1;
      check_all("reset_release");
   endtask

   function automatic logic [3:0] onehot(input int d);
      logic [3:0] v;
      v = 4'd0;
      v[d] = 1'b1;
      return v;
   endfunction

   // Presses the digits with one idle clock between them; returns right after the last press.
   task automatic enter_code(input int a, input int b, input int c, input int d, input logic s);
      int ds[4];
      ds = '{a, b, c, d};
      for (int i = 0; i < 4; i++) begin
         step(onehot(ds[i]), s);
         if (i < 3) step(4'd0, s);
      end
   endtask

   initial begin
      int lock_len;
      int r;
      int d;
      logic [3:0] v;
      logic [3:0] extra;

      reset              = 1'b1;
      bus.button_presses = 4'd0;
      bus.set_mode       = 1'b0;
      model_reset();
      do_reset();

      // Default code unlocks one clock after the fourth press.
      enter_code(3, 2, 1, 0, 1'b0);
      check("t1.unlocked", 32'(bus.unlocked), 32'd1);
      check("t1.digit_count", 32'(bus.digit_count), 32'd0);
      step(4'd0, 1'b0);
      step(4'b0001, 1'b0);
      check("t1.relock", 32'(bus.unlocked), 32'd0);

      // Three wrong entries lock the controller out for exactly LOCK clocks.
      enter_code(0, 0, 0, 0, 1'b0);
      check("t2.err1", 32'(bus.error_pulse), 32'd1);
      step(4'd0, 1'b0);
      enter_code(0, 0, 0, 0, 1'b0);
      step(4'd0, 1'b0);
      enter_code(0, 0, 0, 0, 1'b0);
      check("t2.lockout", 32'(bus.lockout), 32'd1);
      lock_len = 1;
      for (int i = 0; i < 60; i++) begin
         step((i % 3 == 0) ? 4'b1000 : 4'd0, 1'b0);
         if (!bus.lockout) break;
         lock_len++;
      end
      check("t2.lockout_len", 32'(lock_len), 32'(LOCK));

      // Code change to 1,1,2,2; old code then fails and the new one unlocks.
      enter_code(3, 2, 1, 0, 1'b0);
      step(4'd0, 1'b1);
      step(4'b0100, 1'b1);
      step(4'd0, 1'b1);
      enter_code(1, 1, 2, 2, 1'b1);
      check("t3.updated", 32'(bus.code_updated), 32'd1);
      step(4'd0, 1'b0);
      step(4'b0001, 1'b0);
      enter_code(3, 2, 1, 0, 1'b0);
      check("t3.old_fails", 32'(bus.error_pulse), 32'd1);
      step(4'd0, 1'b0);
      enter_code(1, 1, 2, 2, 1'b0);
      check("t3.new_unlocks", 32'(bus.unlocked), 32'd1);
      step(4'b0001, 1'b0);

      // Partial entry is dropped after TMO idle clocks without counting as a failure.
      step(4'b0010, 1'b0);
      step(4'b0010, 1'b0);
      for (int i = 0; i < TMO + 2; i++) step(4'd0, 1'b0);
      check("t4.cleared", 32'(bus.digit_count), 32'd0);
      enter_code(1, 1, 2, 2, 1'b0);
      check("t4.unlock", 32'(bus.unlocked), 32'd1);
      step(4'b0001, 1'b0);

      // Multi-bit press decodes to lowest index; a press on the expiry clock is kept.
      step(4'b1010, 1'b0);
      check("t5.multi", 32'(bus.digit_count), 32'd1);
      for (int i = 0; i < TMO - 1; i++) step(4'd0, 1'b0);
      step(4'b0010, 1'b0);
      check("t5.edge_press", 32'(bus.digit_count), 32'd2);
      step(4'b0100, 1'b0);
      step(4'b0100, 1'b0);
      check("t5.unlock", 32'(bus.unlocked), 32'd1);
      step(4'b0001, 1'b0);

      // Reset during lockout and during code change restores the default code.
      for (int k = 0; k < MAXF; k++) begin
         enter_code(0, 0, 0, 0, 1'b0);
         step(4'd0, 1'b0);
      end
      check("t6.in_lockout", 32'(bus.lockout), 32'd1);
      do_reset();
      enter_code(3, 2, 1, 0, 1'b0);
      check("t6.default_a", 32'(bus.unlocked), 32'd1);
      step(4'b0001, 1'b1);
      step(4'b0001, 1'b1);
      step(4'b0001, 1'b1);
      do_reset();
      enter_code(3, 2, 1, 0, 1'b0);
      check("t6.default_b", 32'(bus.unlocked), 32'd1);

      // Random traffic, biased toward the currently correct next digit.
      for (int n = 0; n < 1500; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            do_reset();
         end else if (r < 4) begin
            for (int i = 0; i < TMO + 2; i++) step(4'd0, 1'($urandom));
         end else if (r < 40) begin
            if ($urandom_range(0, 1) == 1 && m_state == MLocked) begin
               d     = m_code[m_entry.size()];
               v     = onehot(d);
               extra = 4'($urandom);
               for (int i = 0; i < 4; i++) if (i > d && extra[i]) v[i] = 1'b1;
            end else begin
               v = 4'($urandom_range(1, 15));
            end
            step(v, ($urandom_range(0, 3) == 0));
         end else begin
            step(4'd0, 1'($urandom));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
